fnd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 6-digit common-cathode FND on the FPGA board. It holds a 6-digit hex/BCD value plus per-digit decimal points, steps through the digits one at a time, and drives the active-low digit commons. It also presents the selected digit's 4-bit number and dot to the downstream FND segment decoder. The top level ORs `o_dot` into segment bit 0 after the decoder.

---
 rtl/fnd_scan_ctrl_if.sv | 23 ++
 rtl/fnd_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_ctrl_if.sv
// Bus bundle for fnd_scan_ctrl: shadow load/enable inputs and the per-digit scan outputs.
// master drives the inputs and observes the scan outputs; slave is the controller side.
interface fnd_scan_ctrl_if;
  logic        i_load;
  logic [23:0] i_nums;
  logic [5:0]  i_dots;
  logic        i_en;
  logic [5:0]  o_com;
  logic [3:0]  o_num;
  logic        o_dot;
  logic [2:0]  o_digit;
  logic        o_frame;

  modport master (
    output i_load, i_nums, i_dots, i_en,
    input  o_com, o_num, o_dot, o_digit, o_frame
  );

  modport slave (
    input  i_load, i_nums, i_dots, i_en,
    output o_com, o_num, o_dot, o_digit, o_frame
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// 6-digit common-cathode FND scan controller: OFF/SHOW/GAP stepping with shadowed digit data.
// Optional leading-zero blanking when FND_SCAN_LZB_EN is defined.
module fnd_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fnd_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {OFF, SHOW, GAP} state_e;

  localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  state_e          state_q;
  logic [2:0]      idx_q;
  logic [CW-1:0]   cnt_q;
  logic [23:0]     nums_q;
  logic [5:0]      dots_q;
  logic [5:0]      com_q;
  logic [3:0]      num_q;
  logic            dot_q;
  logic            frame_q;

  logic [2:0]      idx_nxt;
  logic [3:0]      sel_num;
  logic            sel_dot;
  logic            blank;
  logic [5:0]      com_nxt;
  logic            last_div;
  logic            last_blank;
  logic            go_show;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nums_q <= '0;
      dots_q <= '0;
    end else if (bus.i_load) begin
      nums_q <= bus.i_nums;
      dots_q <= bus.i_dots;
    end
  end

  // Everything describing the next digit is taken from the shadow as it stands before the edge.
  always_comb begin
    idx_nxt = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    sel_num = nums_q[{idx_nxt, 2'b00} +: 4];
    sel_dot = dots_q[idx_nxt];
`ifdef FND_SCAN_LZB_EN
    blank   = (idx_nxt != 3'd0) &&
              ((nums_q >> {idx_nxt, 2'b00}) == 24'd0) &&
              ((dots_q >> idx_nxt) == 6'd0);
`else
    blank   = 1'b0;
`endif
    com_nxt    = blank ? 6'h3F : ~(6'd1 << idx_nxt);
    last_div   = (cnt_q == CW'(DIV - 1));
    last_blank = (cnt_q == CW'(BLANK - 1));
    go_show    = ((state_q == SHOW) && last_div && (BLANK == 0)) ||
                 ((state_q == GAP) && last_blank);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      com_q   <= 6'h3F;
      num_q   <= '0;
      dot_q   <= 1'b0;
      frame_q <= 1'b0;
    end else if (!bus.i_en) begin
      state_q <= OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      com_q   <= 6'h3F;
      num_q   <= '0;
      dot_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      case (state_q)
        OFF: begin
          // Digit 0 is never blanked, and entry from OFF is not a frame start.
          state_q <= SHOW;
          idx_q   <= '0;
          cnt_q   <= '0;
          com_q   <= 6'b111110;
          num_q   <= nums_q[3:0];
          dot_q   <= dots_q[0];
          frame_q <= 1'b0;
        end
        SHOW, GAP: begin
          frame_q <= 1'b0;
          if (go_show) begin
            state_q <= SHOW;
            idx_q   <= idx_nxt;
            cnt_q   <= '0;
            com_q   <= com_nxt;
            num_q   <= blank ? 4'd0 : sel_num;
            dot_q   <= blank ? 1'b0 : sel_dot;
            frame_q <= (idx_nxt == 3'd0);
          end else if ((state_q == SHOW) && last_div) begin
            state_q <= GAP;
            cnt_q   <= '0;
            com_q   <= 6'h3F;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= OFF;
          idx_q   <= '0;
          cnt_q   <= '0;
          com_q   <= 6'h3F;
          frame_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_com   = com_q;
  assign bus.o_num   = num_q;
  assign bus.o_dot   = dot_q;
  assign bus.o_digit = idx_q;
  assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: directed table, hand sequences and random traffic against a slot-time model.
// Instance A uses DIV=4/BLANK=2, instance B uses DIV=4/BLANK=0.
module tb_fnd_scan_ctrl;
  localparam int DIV = 4;
  localparam int BA  = 2;
  localparam int BB  = 0;
`ifdef FND_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fnd_scan_ctrl_if ifa();
  fnd_scan_ctrl_if ifb();

  fnd_scan_ctrl #(.DIV(DIV), .BLANK(BA)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  fnd_scan_ctrl #(.DIV(DIV), .BLANK(BB)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int vectors     = 0;
  int miscompares = 0;

  // Model: time since scan start, slot = DIV+BLANK cycles, digit data captured at slot start.
  bit          m_run [2];
  int          m_t   [2];
  int          m_per [2];
  logic [23:0] m_sn  [2];
  logic [5:0]  m_sd  [2];
  logic [3:0]  m_num [2];
  logic        m_dot [2];
  bit          m_blk [2];

  typedef struct {
    logic        ld;
    logic [23:0] nums;
    logic [5:0]  dots;
    logic        en;
    logic [5:0]  com;
    logic [3:0]  num;
    logic        dot;
    logic [2:0]  dig;
    logic        fr;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic ld, logic [23:0] nums, logic [5:0] dots, logic en,
                              logic [5:0] com, logic [3:0] num, logic dot, logic [2:0] dig, logic fr);
    vec_t v;
    v.ld = ld; v.nums = nums; v.dots = dots; v.en = en;
    v.com = com; v.num = num; v.dot = dot; v.dig = dig; v.fr = fr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_t[k] = 0; m_sn[k] = '0; m_sd[k] = '0;
      m_num[k] = '0; m_dot[k] = 1'b0; m_blk[k] = 0;
    end
  endtask

  task automatic capture(input int k, input int d);
    m_blk[k] = LZB && (d > 0) && ((m_sn[k] >> (4 * d)) == 24'd0) && ((m_sd[k] >> d) == 6'd0);
    m_num[k] = m_blk[k] ? 4'd0 : m_sn[k][4*d +: 4];
    m_dot[k] = m_blk[k] ? 1'b0 : m_sd[k][d];
  endtask

  task automatic model_edge(input int k, input logic en, input logic ld,
                            input logic [23:0] nums, input logic [5:0] dots);
    if (!en) begin
      m_run[k] = 0;
    end else if (!m_run[k]) begin
      m_run[k] = 1; m_t[k] = 0; capture(k, 0);
    end else begin
      m_t[k]++;
      if (m_t[k] % m_per[k] == 0) capture(k, (m_t[k] / m_per[k]) % 6);
    end
    if (ld) begin
      m_sn[k] = nums; m_sd[k] = dots;
    end
  endtask

  task automatic check(input int k, input string tag);
    logic [5:0] com, ecom;
    logic [3:0] num;
    logic       dot, fr, efr;
    logic [2:0] dig, edig;
    int         ph, d;
    if (k == 0) begin
      com = ifa.o_com; num = ifa.o_num; dot = ifa.o_dot; dig = ifa.o_digit; fr = ifa.o_frame;
    end else begin
      com = ifb.o_com; num = ifb.o_num; dot = ifb.o_dot; dig = ifb.o_digit; fr = ifb.o_frame;
    end
    if (!m_run[k]) begin
      ecom = 6'h3F; edig = 3'd0; efr = 1'b0;
    end else begin
      ph   = m_t[k] % m_per[k];
      d    = (m_t[k] / m_per[k]) % 6;
      ecom = (ph < DIV && !m_blk[k]) ? ~(6'd1 << d) : 6'h3F;
      edig = 3'(d);
      efr  = (ph == 0) && (d == 0) && (m_t[k] > 0);
    end
    chk({tag, ".com"}, 32'(com), 32'(ecom));
    chk({tag, ".digit"}, 32'(dig), 32'(edig));
    chk({tag, ".frame"}, 32'(fr), 32'(efr));
    if (m_run[k]) begin
      chk({tag, ".num"}, 32'(num), 32'(m_num[k]));
      chk({tag, ".dot"}, 32'(dot), 32'(m_dot[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_edge(0, ifa.i_en, ifa.i_load, ifa.i_nums, ifa.i_dots);
      model_edge(1, ifb.i_en, ifb.i_load, ifb.i_nums, ifb.i_dots);
    end
    #1;
    check(0, "A");
    check(1, "B");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int fr_last;
  int fr_seen;
  int r;

  initial begin
    m_per[0] = DIV + BA;
    m_per[1] = DIV + BB;
    model_reset();

    tbl[0]  = mk(1, 24'h654321, 6'b000100, 0, 6'h3F,      4'd0, 0, 3'd0, 0);
    for (int i = 1; i <= 4; i++)  tbl[i] = mk(0, 24'h654321, 6'b000100, 1, 6'b111110, 4'd1, 0, 3'd0, 0);
    for (int i = 5; i <= 6; i++)  tbl[i] = mk(0, 24'h654321, 6'b000100, 1, 6'h3F,     4'd1, 0, 3'd0, 0);
    for (int i = 7; i <= 10; i++) tbl[i] = mk(0, 24'h654321, 6'b000100, 1, 6'b111101, 4'd2, 0, 3'd1, 0);
    for (int i = 11; i <= 12; i++) tbl[i] = mk(0, 24'h654321, 6'b000100, 1, 6'h3F,    4'd2, 0, 3'd1, 0);
    tbl[13] = mk(0, 24'h654321, 6'b000100, 1, 6'b111011,  4'd3, 1, 3'd2, 0);

    ifa.i_load = 0; ifa.i_nums = '0; ifa.i_dots = '0; ifa.i_en = 0;
    ifb.i_load = 0; ifb.i_nums = '0; ifb.i_dots = '0; ifb.i_en = 0;

    // Reset held while clocking, with enable and load asserted.
    ifa.i_en = 1; ifa.i_load = 1; ifa.i_nums = 24'h123456;
    run(3);
    chk("rst.num", 32'(ifa.o_num), 0);
    chk("rst.dot", 32'(ifa.o_dot), 0);
    chk("rst.com", 32'(ifa.o_com), 32'h3F);
    ifa.i_en = 0; ifa.i_load = 0;
    rst_n = 1;

    for (int i = 0; i < 14; i++) begin
      ifa.i_load = tbl[i].ld; ifa.i_nums = tbl[i].nums; ifa.i_dots = tbl[i].dots; ifa.i_en = tbl[i].en;
      step();
      chk($sformatf("tbl%0d.com", i), 32'(ifa.o_com), 32'(tbl[i].com));
      chk($sformatf("tbl%0d.digit", i), 32'(ifa.o_digit), 32'(tbl[i].dig));
      chk($sformatf("tbl%0d.frame", i), 32'(ifa.o_frame), 32'(tbl[i].fr));
      if (tbl[i].en) begin
        chk($sformatf("tbl%0d.num", i), 32'(ifa.o_num), 32'(tbl[i].num));
        chk($sformatf("tbl%0d.dot", i), 32'(ifa.o_dot), 32'(tbl[i].dot));
      end
    end

    // Frame pulse 36 cycles after the first digit-0 entry, for exactly one cycle.
    run(23);
    step();
    chk("frame36.pulse", 32'(ifa.o_frame), 1);
    chk("frame36.com", 32'(ifa.o_com), 32'h3E);
    step();
    chk("frame36.low", 32'(ifa.o_frame), 0);

    // Load during the second cycle of digit 1: digit 1 keeps old data, digit 2 shows new.
    run(5);
    ifa.i_load = 1; ifa.i_nums = 24'hABCDEF; ifa.i_dots = 6'd0;
    step();
    ifa.i_load = 0;
    chk("midload.num", 32'(ifa.o_num), 2);
    run(5);
    chk("midload.d2num", 32'(ifa.o_num), 32'hD);
    chk("midload.d2com", 32'(ifa.o_com), 32'h3B);

    // Drop enable inside digit 3, then re-enable.
    run(7);
    chk("en_drop.pre", 32'(ifa.o_digit), 3);
    ifa.i_en = 0;
    step();
    chk("en_drop.com", 32'(ifa.o_com), 32'h3F);
    ifa.i_en = 1;
    step();
    chk("reen.com", 32'(ifa.o_com), 32'h3E);
    chk("reen.frame", 32'(ifa.o_frame), 0);
    chk("reen.num", 32'(ifa.o_num), 32'hF);

    // Asynchronous reset between edges.
    run(2);
    #2 rst_n = 0;
    #1;
    chk("areset.com", 32'(ifa.o_com), 32'h3F);
    chk("areset.num", 32'(ifa.o_num), 0);
    chk("areset.digit", 32'(ifa.o_digit), 0);
    model_reset();
    run(2);
    rst_n = 1;
    ifa.i_en = 0;

    // Instance B, no blanking gap: every running cycle has a lit digit, frame every 24 cycles.
    ifb.i_load = 1; ifb.i_nums = 24'h654321; ifb.i_dots = 6'b000100; ifb.i_en = 1;
    step();
    ifb.i_load = 0;
    chk("b_entry.num", 32'(ifb.o_num), 0);
    fr_last = -1; fr_seen = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      chk("b_nogap", 32'(ifb.o_com != 6'h3F), 1);
      if (ifb.o_frame) begin
        if (fr_last >= 0) chk("b_period", 32'(i - fr_last), 24);
        fr_last = i; fr_seen++;
      end
    end
    chk("b_frames", 32'(fr_seen), 2);

    // Leading-zero case on instance B.
    ifb.i_en = 0; ifb.i_load = 1; ifb.i_nums = 24'h000042; ifb.i_dots = 6'd0;
    step();
    ifb.i_load = 0; ifb.i_en = 1;
    step();
    chk("lz.d0num", 32'(ifb.o_num), 2);
    run(4);
    chk("lz.d1com", 32'(ifb.o_com), 32'h3D);
    chk("lz.d1num", 32'(ifb.o_num), 4);
    run(4);
    chk("lz.d2digit", 32'(ifb.o_digit), 2);
    chk("lz.d2com", 32'(ifb.o_com), LZB ? 32'h3F : 32'h3B);
    run(12);
    chk("lz.d5digit", 32'(ifb.o_digit), 5);
    chk("lz.d5com", 32'(ifb.o_com), LZB ? 32'h3F : 32'h1F);
    chk("lz.d5num", 32'(ifb.o_num), 0);
    ifb.i_en = 0;
    step();

    // Random traffic on instance A.
    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 99);
      ifa.i_load = (r < 8);
      if (r < 8) begin
        ifa.i_nums = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 5)));
        ifa.i_dots = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      end
      ifa.i_en = (r < 97);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
